ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_fifo.sv | 59 +++++
 rtl/ps2_rx_fifo.sv | 125 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: framing states, frame size,
// default sizing and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam int FRAME_BITS      = 8;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DEF_TIMEOUT_CYC = 20000;

    // PS/2 uses odd parity: the eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead scancode FIFO. A push into a full FIFO is dropped unless
// a pop happens in the same cycle.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    wr_data,
    input  logic                          pop,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          dropped
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot this very cycle, so a full FIFO still accepts the push.
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;
    assign count   = cnt;
    assign rd_data = empty ? 8'h00 : mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, deframes 11-bit frames and
// queues good scancodes for the CPU, with sticky overflow and framing-error flags.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_s1, clk_s2, clk_s3;
    logic          dat_s1, dat_s2;
    logic          fall;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          push;
    logic          frame_bad;
    logic          full;
    logic          dropped;

    // Synchronizers reset high so an idle line produces no spurious falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall    = clk_s3 & ~clk_s2;
    assign tmo_hit = (state != ST_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Push combinationally on the stop-bit edge so the byte is visible one cycle later.
    assign push = fall && (state == ST_STOP) && dat_s2 && odd_parity_ok(shift, par_bit);

    assign frame_bad = (fall && (state == ST_IDLE) && dat_s2)
                     || (fall && (state == ST_STOP) && !push)
                     || tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == ST_IDLE || fall) tmo_cnt <= '0;
            else                          tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit) begin
                state <= ST_IDLE;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!dat_s2) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(FRAME_BITS - 1)) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= ST_STOP;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Clearing wins over a same-cycle error so software never misses its acknowledge.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (frame_bad) frame_err <= 1'b1;
            if (dropped)   overflow  <= 1'b1;
        end
    end

    ps2_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (shift),
        .pop     (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .dropped (dropped)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed scenarios plus randomized frames
// checked against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

    localparam int FD  = 8;
    localparam int TMO = 300;
    localparam int H   = 20;
    localparam int CW  = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [7:0]    rd_data;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    logic       m_ovf  = 1'b0;
    logic       m_ferr = 1'b0;

    logic          snap_empty_pre;
    logic          snap_empty;
    logic [7:0]    snap_data;
    logic [CW-1:0] snap_count;

    ps2_rx_fifo #(
        .FIFO_DEPTH (FD),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .frame_err(frame_err),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] head();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic v, input bit snap, input bit pop);
        ps2_data = v;
        tick(H);
        ps2_clk = 1'b0;
        if (snap) begin
            tick(2);
            snap_empty_pre = empty;
            rd_en = pop;
            tick(1);
            rd_en = 1'b0;
            snap_data  = rd_data;
            snap_count = count;
            snap_empty = empty;
            tick(H - 3);
        end else begin
            tick(H);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_at_stop);
        bit good;
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 0, 0);
        ps2_bit((~^b) ^ bad_par, 0, 0);
        ps2_bit(~bad_stop, 1, pop_at_stop);
        tick(H);
        good = !bad_par && !bad_stop;
        if (pop_at_stop && mq.size() > 0) mq.delete(0);
        if (good) begin
            if (mq.size() < FD) mq.push_back(b);
            else                m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        if (clr_err) begin
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0, 0, 0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i], 0, 0);
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (mq.size() > 0) mq.delete(0);
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b1; clr_err = 1'b1;
        tick(3);
        rst = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        tick(1);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    endtask

    task automatic test_single_frame();
        send_frame(8'h1C, 0, 0, 0);
        n_tests++; if (snap_empty_pre !== 1'b1) begin n_fail++; $display("FAIL latency_early got empty=%b want 1", snap_empty_pre); end
        n_tests++; if (snap_data !== 8'h1C) begin n_fail++; $display("FAIL latency_data got %h want 1c", snap_data); end
        n_tests++; if (snap_count !== CW'(1)) begin n_fail++; $display("FAIL latency_count got %0d want 1", snap_count); end
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b want 0", empty); end
        n_tests++; if (rd_data !== 8'h1C) begin n_fail++; $display("FAIL single_data got %h want 1c", rd_data); end
        n_tests++; if ({overflow, frame_err} !== 2'b00) begin n_fail++; $display("FAIL single_flags got %b%b want 00", overflow, frame_err); end
    endtask

    task automatic test_two_and_pop();
        do_pop();
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        n_tests++; if (count !== CW'(2)) begin n_fail++; $display("FAIL two_count got %0d want 2", count); end
        n_tests++; if (rd_data !== 8'hF0) begin n_fail++; $display("FAIL two_head got %h want f0", rd_data); end
        do_pop();
        n_tests++; if (rd_data !== 8'h1C) begin n_fail++; $display("FAIL two_second got %h want 1c", rd_data); end
        do_pop();
        n_tests++; if ({empty, rd_data} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL two_drained got empty=%b data=%h want 1/00", empty, rd_data); end
        do_pop();
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL pop_empty_count got %0d want 0", count); end
    endtask

    task automatic test_parity_err();
        send_frame(8'h1C, 1, 0, 0);
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL parity_count got %0d want 0", count); end
        n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL parity_err got %b want 1", frame_err); end
        clr_pulse();
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL clr_err got %b want 0", frame_err); end
        clr_err = 1'b1;
        send_frame(8'h1C, 1, 0, 0);
        clr_err = 1'b0;
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL clr_priority got %b want 0", frame_err); end
        send_frame(8'h2B, 0, 1, 0);
        n_tests++; if ({frame_err, count} !== {1'b1, CW'(0)}) begin n_fail++; $display("FAIL stop_err got err=%b count=%0d want 1/0", frame_err, count); end
        clr_pulse();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
        n_tests++; if (count !== CW'(FD)) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", count, FD); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        n_tests++; if (rd_data !== 8'h01) begin n_fail++; $display("FAIL ovf_head got %h want 01", rd_data); end
        clr_pulse();
        send_frame(8'h0A, 0, 0, 1);
        n_tests++; if ({overflow, count} !== {1'b0, CW'(FD)}) begin n_fail++; $display("FAIL full_pushpop got ovf=%b count=%0d want 0/%0d", overflow, count, FD); end
        for (int i = 0; i < FD; i++) begin
            n_tests++; if (rd_data !== head()) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h want %h", i, rd_data, head()); end
            do_pop();
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got %b want 1", empty); end
    endtask

    task automatic test_timeout();
        send_partial(8'h55, 4);
        tick(TMO + 40);
        n_tests++; if ({frame_err, count} !== {1'b1, CW'(0)}) begin n_fail++; $display("FAIL timeout got err=%b count=%0d want 1/0", frame_err, count); end
        clr_pulse();
        send_frame(8'h32, 0, 0, 0);
        n_tests++; if ({rd_data, count, frame_err} !== {8'h32, CW'(1), 1'b0}) begin n_fail++; $display("FAIL after_timeout got %h/%0d/%b want 32/1/0", rd_data, count, frame_err); end
        do_pop();
    endtask

    task automatic test_mid_reset();
        send_frame(8'h11, 0, 0, 0);
        send_frame(8'h22, 1, 0, 0);
        send_partial(8'h99, 3);
        tick(5);
        rst = 1'b1; rd_en = 1'b1; clr_err = 1'b0;
        tick(1);
        rst = 1'b0; rd_en = 1'b0;
        tick(1);
        mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
        n_tests++; if ({empty, count, rd_data, overflow, frame_err} !== {1'b1, CW'(0), 8'h00, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL midrst_state got %b/%0d/%h/%b/%b want 1/0/00/0/0", empty, count, rd_data, overflow, frame_err); end
        send_frame(8'h5A, 0, 0, 0);
        n_tests++; if ({rd_data, count, frame_err} !== {8'h5A, CW'(1), 1'b0}) begin n_fail++; $display("FAIL midrst_frame got %h/%0d/%b want 5a/1/0", rd_data, count, frame_err); end
        do_pop();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int k;
        for (int it = 0; it < 20; it++) begin
            b = 8'($urandom);
            k = $urandom_range(0, 9);
            send_frame(b, k == 8, k == 9, $urandom_range(0, 3) == 0);
            for (int p = $urandom_range(0, 2); p > 0; p--) do_pop();
            n_tests++; if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rand_count[%0d] got %0d want %0d", it, count, mq.size()); end
            n_tests++; if (rd_data !== head()) begin n_fail++; $display("FAIL rand_head[%0d] got %h want %h", it, rd_data, head()); end
            n_tests++; if ({overflow, frame_err} !== {m_ovf, m_ferr}) begin n_fail++; $display("FAIL rand_flags[%0d] got %b%b want %b%b", it, overflow, frame_err, m_ovf, m_ferr); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_two_and_pop();
        test_parity_err();
        test_overflow();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
